muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode constants, FSM encoding and default width for the RV32M sequencer.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared {hi, lo} accumulator: shift-add multiply
// (multiplier in lo, consumed LSB first) or restoring divide (dividend in lo,
// quotient bits shifted in from the right, partial remainder in hi).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  // Single iteration datapath; both variants computed, opcode class selects.
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    fits   = (rem_sh >= {1'b0, opnd_i});
    if (is_div) begin
      if (fits) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else      acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN iterations) -> FIN,
// with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam logic [5:0] LAST = 6'(XLEN - 1);

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_step;

  logic                a_sgn, b_sgn, a_neg, b_neg, is_div_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;

  // Apply the sign recorded at acceptance and pick the architectural half.
  function automatic logic [XLEN-1:0] fin_result(input logic [2:0] op,
                                                 input logic neg,
                                                 input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])             return op[1] ? rem : quo;
    else if (op == F3_MUL) return prod[XLEN-1:0];
    else                   return prod[2*XLEN-1:XLEN];
  endfunction

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Operand decode at acceptance: signedness per opcode, magnitudes, fast-path detection.
  always_comb begin
    is_div_in = funct3[2];
    a_sgn     = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn     = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg     = a_sgn && a[XLEN-1];
    b_neg     = b_sgn && b[XLEN-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    div_zero  = FAST_ZERO && is_div_in && (b == '0);
    div_ovf   = FAST_ZERO && is_div_in && !funct3[0] &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  end

  // Next-state and datapath update; flush overrides everything and keeps result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d = funct3;
          if (div_zero) begin
            result_d = funct3[1] ? a : '1;
            state_d  = ST_FIN;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : a;
            state_d  = ST_FIN;
          end else begin
            neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            opnd_d  = is_div_in ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          result_d = fin_result(op_q, neg_q, acc_step);
          state_d  = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;
  assign stall  = (start && (state_q == ST_IDLE) && !flush) || (state_q == ST_CALC);

endmodule
